// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the CPU run/halt/step controller.
// State values are exported on the controller's state port.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } st_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20'd500000;

endpackage

// File: rtl/step_debounce.sv
// step_debounce: synchronizes the step button, optionally debounces it,
// and emits a one-cycle press on the rising edge of the clean level.
// Debounce counter is built only when CPU_STEP_DEBOUNCE_EN is defined.
module step_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level_q;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef CPU_STEP_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic          db;

  // Adopt the synchronized value only after it has disagreed long enough.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      db  <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = db;
`else
  assign level = sync2;

  // Debounce depth has no effect when the counter is not built.
  if (DEBOUNCE_CYCLES == 0) begin : g_no_depth
  end
`endif

  // Previous clean level, for rising-edge press detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the divided slow clock into one-cycle cpu_en pulses
// under run/halt/step control. Optional macro: CPU_STEP_DEBOUNCE_EN.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int          CNT_W           = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             clr_cnt,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  logic run_s1;
  logic run_s;
  logic slow_q;
  logic slow_qq;
  logic arm_q;
  logic arm_qq;
  logic tick;
  logic press;
  logic unused_step_level;
  st_t  st_q;
  st_t  st_d;
  logic en_q;
  logic en_d;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clock(clock),
    .reset(reset),
    .btn  (step_btn),
    .level(unused_step_level),
    .press(press)
  );

  // Two-flop synchronizer for the run switch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      run_s1 <= run_sw;
      run_s  <= run_s1;
    end
  end

  // Slow clock edge detector; arm bits stop a level that is already
  // high at reset release from looking like a rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slow_q  <= 1'b0;
      slow_qq <= 1'b0;
      arm_q   <= 1'b0;
      arm_qq  <= 1'b0;
    end else begin
      slow_q  <= slow_clk;
      slow_qq <= slow_q;
      arm_q   <= 1'b1;
      arm_qq  <= arm_q;
    end
  end

  assign tick = slow_q & ~slow_qq & arm_qq;

  // State and pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q <= ST_HALT;
      en_q <= 1'b0;
    end else begin
      st_q <= st_d;
      en_q <= en_d;
    end
  end

  // Next state and pulse request; halt_req always wins.
  always_comb begin
    st_d = st_q;
    en_d = 1'b0;
    unique case (st_q)
      ST_HALT: begin
        if (halt_req)   st_d = ST_HALT;
        else if (run_s) st_d = ST_RUN;
        else if (press) st_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req || !run_s) st_d = ST_HALT;
        else                    en_d = tick;
      end
      ST_STEP: begin
        if (halt_req) begin
          st_d = ST_HALT;
        end else if (tick) begin
          en_d = 1'b1;
          st_d = ST_HALT;
        end
      end
      default: st_d = ST_HALT;
    endcase
  end

  // Saturating count of issued pulses; clear has priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (clr_cnt) begin
      cycle_count <= '0;
    end else if (en_q && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign cpu_en = en_q;
  assign state  = st_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench with a history-based reference model.
// Follows CPU_STEP_DEBOUNCE_EN the same way the design does.
module tb_cpu_step_ctrl;

  localparam int CNT_W = 4;
  localparam int DB    = 4;
  localparam int N     = 4096;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clock    = 1'b0;
  logic reset    = 1'b0;
  logic slow_clk = 1'b0;
  logic run_sw   = 1'b0;
  logic step_btn = 1'b0;
  logic halt_req = 1'b0;
  logic clr_cnt  = 1'b0;
  logic             cpu_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_count;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .halt_req   (halt_req),
    .clr_cnt    (clr_cnt),
    .cpu_en     (cpu_en),
    .state      (state),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    bit en;
    int st;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total  = 0;
  int   bad    = 0;
  int   ecount = 0;
  int   phase  = 0;

  // Input history since reset release, indexed by edge number.
  bit slow_h[N];
  bit run_h[N];
  bit btn_h[N];
  bit lev_h[N];
  int mk;
  int m_st;
  bit m_en;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, want);
    end
  endtask

  // Synchronized button seen after edge j: the input two edges back.
  function automatic bit sv(int j);
    return (j >= 2) ? btn_h[j-1] : 1'b0;
  endfunction

  function automatic void model_reset();
    mk       = 0;
    m_st     = 0;
    m_en     = 1'b0;
    m_cnt    = 0;
    lev_h[0] = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step(bit r, bit b, bit h, bit c, bit s);
    int k;
    bit tk;
    bit rs;
    bit pr;
    bit nen;
    int nst;
    int ncnt;
`ifdef CPU_STEP_DEBOUNCE_EN
    bit flip;
`endif
    mk++;
    k = mk;
    slow_h[k] = s;
    run_h[k]  = r;
    btn_h[k]  = b;
`ifdef CPU_STEP_DEBOUNCE_EN
    // Level follows only a value held for DB+1 straight samples.
    flip = 1'b1;
    for (int i = 0; i <= DB; i++)
      if (sv(k - 1 - i) == lev_h[k-1]) flip = 1'b0;
    lev_h[k] = flip ? ~lev_h[k-1] : lev_h[k-1];
`else
    lev_h[k] = sv(k);
`endif
    // A rise needs a low sample observed after reset release.
    tk = (k >= 3) && slow_h[k-1] && !slow_h[k-2];
    rs = (k >= 3) && run_h[k-2];
    pr = (k >= 2) && lev_h[k-1] && !lev_h[k-2];
    if (c)         ncnt = 0;
    else if (m_en) ncnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
    else           ncnt = m_cnt;
    nst = m_st;
    nen = 1'b0;
    case (m_st)
      0: begin
        if (!h) begin
          if (rs)      nst = 1;
          else if (pr) nst = 2;
        end
      end
      1: begin
        if (h || !rs) nst = 0;
        else          nen = tk;
      end
      default: begin
        if (h) begin
          nst = 0;
        end else if (tk) begin
          nen = 1'b1;
          nst = 0;
        end
      end
    endcase
    m_st  = nst;
    m_en  = nen;
    m_cnt = ncnt;
    exp_q.push_back('{ecount + 1, nen, nst, ncnt});
  endfunction

  // Drive one cycle of inputs, predict, and move past the edge.
  task automatic cyc(input bit r, input bit b, input bit h, input bit c);
    bit s;
    s     = (phase < 2);
    phase = (phase + 1) % 4;
    run_sw   = r;
    step_btn = b;
    halt_req = h;
    clr_cnt  = c;
    slow_clk = s;
    model_step(r, b, h, c, s);
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) ecount++;

  // Monitor: compare every predicted edge against the DUT.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= ecount) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc == ecount) begin
        chk("cpu_en", cpu_en, mon_e.en);
        chk("state", state, mon_e.st);
        chk("cycle_count", cycle_count, mon_e.cnt);
      end
    end
  end

  initial begin
    bit r;
    bit b;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_en", cpu_en, 0);
    chk("reset_state", state, 0);
    chk("reset_cnt", cycle_count, 0);
    reset = 1'b1;

    repeat (40) cyc(1, 0, 0, 0);
    repeat (4)  cyc(1, 0, 1, 0);
    repeat (12) cyc(1, 0, 0, 0);

    repeat (6)  cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    repeat (12) cyc(0, 0, 0, 0);

    repeat (2)  cyc(0, 1, 0, 0);
    repeat (14) cyc(0, 0, 0, 0);

    repeat (80) cyc(1, 0, 0, 0);
    for (int i = 0; i < 8 && !m_en; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, 0);

    r = 1'b0;
    b = 1'b0;
    repeat (700) begin
      if ($urandom_range(0, 19) == 0) r = ~r;
      if ($urandom_range(0, 9) == 0)  b = ~b;
      cyc(r, b, $urandom_range(0, 9) == 0,
          $urandom_range(0, 29) == 0);
    end

    for (int i = 0; i < 12 && !m_en; i++) cyc(1, 0, 0, 0);
    chk("pre_reset_en", cpu_en, 1);
    #1;
    reset    = 1'b0;
    model_reset();
    slow_clk = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    clr_cnt  = 1'b0;
    #1;
    chk("async_en", cpu_en, 0);
    chk("async_state", state, 0);
    chk("async_cnt", cycle_count, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    phase = 1;
    repeat (30) cyc(1, 0, 0, 0);

    @(negedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Run/halt/single-step controller that converts the divided slow clock into a one-cycle CPU clock-enable pulse in the fast clock domain. It sits directly downstream of the clock divider and upstream of the pipelined CPU core, whose registers advance only when `cpu_en` is high. It also accepts a halt request from the core, a run switch and a step button from the board, and keeps a count of issued CPU cycles.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20'd500000: stable cycles required before the debounced `step_btn` level changes.
- `CNT_W`, default 32: width of `cycle_count`.

Ports:
- `clock` in 1: system clock. This is the single clock for the block.
- `reset` in 1: asynchronous, active-low reset. Low clears all state.
- `slow_clk` in 1: divided clock from the clock divider, treated as a level in the `clock` domain.
- `run_sw` in 1: free-run switch, asynchronous. 1 requests RUN.
- `step_btn` in 1: single-step pushbutton, asynchronous, active-high.
- `halt_req` in 1: synchronous halt from the CPU core, level.
- `clr_cnt` in 1: synchronous clear of `cycle_count`.
- `cpu_en` out 1: one-`clock` pulse per CPU cycle. Registered.
- `state` out 2: current FSM state (HALT=0, RUN=1, STEP=2). Registered.
- `cycle_count` out CNT_W: number of `cpu_en` pulses issued. Saturating.

## Operation
- `run_sw` and `step_btn` each pass through a 2-flop synchronizer. Reset value is 0.
- Edge detection on `slow_clk`:
  - `slow_q` <= `slow_clk` and `slow_qq` <= `slow_q`.
  - `tick` = `slow_q & ~slow_qq`.
- Step press is the rising edge of the debounced step level (see Configuration).
- FSM (reset state HALT):
  - HALT: if `halt_req`=1, stay. Else if `run_sw`=1, go to RUN. Else if step press, go to STEP.
  - RUN: if `halt_req`=1 or `run_sw`=0, go to HALT with no pulse issued that cycle. Else on `tick`, assert `cpu_en` next cycle.
  - STEP: wait for `tick`, then assert `cpu_en` exactly once and return to HALT. `halt_req` in STEP aborts to HALT with no pulse.
- `halt_req` has highest priority in every state. Step presses in RUN or STEP are ignored, not queued.
- `cycle_count`:
  - +1 on each cycle where `cpu_en`=1.
  - Holds at all-ones once saturated.
  - `clr_cnt` forces 0 and wins over the increment in the same cycle.

## Timing
- Reset values: `cpu_en`=0, `state`=0, `cycle_count`=0. All synchronizer, edge and debounce registers are 0.
- `slow_clk` first sampled high at edge N: `tick` is true during cycle N+1, and `cpu_en` is high after edge N+1 for exactly one cycle.
- At most one `cpu_en` per `slow_clk` rising edge. `cpu_en` is never high on two consecutive cycles.
- `run_sw` change to a state change takes 3 edges: 2 for the synchronizer, 1 for the state register.
- `cycle_count` reflects a `cpu_en` pulse one cycle after that pulse.
- Reset asserted mid-pulse: `cpu_en` drops immediately (asynchronous). After release, the block is in HALT with no pending step.
- A `slow_clk` that is high when reset releases does not produce a `tick` until its next rising edge.

## Configuration
- `CPU_STEP_DEBOUNCE_EN` defined:
  - A counter of width `$clog2(DEBOUNCE_CYCLES+1)` runs while the synchronized `step_btn` differs from the debounced level.
  - The counter resets to 0 whenever the two agree.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value.
- `CPU_STEP_DEBOUNCE_EN` undefined:
  - The debounced level equals the synchronized `step_btn`. No counter is built.
  - `DEBOUNCE_CYCLES` is ignored.

## Structure
- Shared package `cpu_ctrl_pkg`: state encoding constants `ST_HALT`=2'd0, `ST_RUN`=2'd1, `ST_STEP`=2'd2, and the default `DEBOUNCE_CYCLES`.
- Sub-module `step_debounce` (clock, reset, async in, debounced level out, step press pulse out). It contains the synchronizer and the optional debounce counter.
- FSM, `slow_clk` edge detector and cycle counter stay in `cpu_step_ctrl`.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4, `CNT_W`=4, `slow_clk` period 4 `clock` cycles.
- Reset then `run_sw`=1 for 40 cycles: `state`=RUN, one `cpu_en` per 4 cycles, each 1 cycle wide, 2 edges after `slow_clk` rises. `cycle_count` matches the pulse count.
- In RUN, assert `halt_req` in the cycle before a pulse is due: no `cpu_en`, `state`=HALT. Deasserting `halt_req` with `run_sw`=1 resumes RUN.
- In HALT, `step_btn` high for 10 cycles: `state`=STEP, then exactly one `cpu_en` at the next `tick`, back to HALT, `cycle_count`+1.
- With the macro defined, a 2-cycle `step_btn` glitch gives no step. Without the macro, the same glitch gives one step.
- Run to 15 pulses, then more: `cycle_count` stays at 4'hF. `clr_cnt` together with `cpu_en` gives `cycle_count`=0.
- Reset low during a `cpu_en` pulse: `cpu_en`=0 immediately, and after release `state`=HALT and `cycle_count`=0.
